// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch sequencer, the instruction bus and the ID stage.
// master = fetch_ctrl; slave = bus/pipeline side.
interface fetch_ctrl_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_flag;
  logic [31:0] br_addr;
  logic        usermode;
  logic        id_stall;
  logic        ib_req;
  logic [31:0] ib_addr;
  logic        ib_gnt;
  logic        ib_rvalid;
  logic [31:0] ib_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  modport master (
    input  flush, flush_pc, br_flag, br_addr, usermode, id_stall,
    input  ib_gnt, ib_rvalid, ib_rdata,
    output ib_req, ib_addr, if_valid, if_pc, if_inst, if_adel
  );

  modport slave (
    output flush, flush_pc, br_flag, br_addr, usermode, id_stall,
    output ib_gnt, ib_rvalid, ib_rdata,
    input  ib_req, ib_addr, if_valid, if_pc, if_inst, if_adel
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one bus request at a time,
// buffers one instruction for ID and applies branch (after delay slot) and flush redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic           clk_i,
  input logic           rst_ni,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic        br_pend_q;
  logic [31:0] br_tgt_q;
  logic        drop_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_inst_q;
  logic        buf_adel_q;

  logic adel;
  logic req;
  logic hold;

  // Misaligned fetch, or kernel segment touched from user mode.
  assign adel = (fetch_pc_q[1:0] != 2'b00) || (bus.usermode && fetch_pc_q[31]);
  assign req  = (state_q == StReq) && !adel;
  assign hold = (state_q == StHold);

  assign bus.ib_req   = req;
  assign bus.ib_addr  = fetch_pc_q;
  assign bus.if_valid = hold;
  assign bus.if_pc    = hold ? buf_pc_q   : 32'h0;
  assign bus.if_inst  = hold ? buf_inst_q : 32'h0;
  assign bus.if_adel  = hold ? buf_adel_q : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= 32'h0;
      drop_q     <= 1'b0;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= 32'h0;
      buf_adel_q <= 1'b0;
    end else if (bus.flush) begin
      br_pend_q  <= 1'b0;
      fetch_pc_q <= bus.flush_pc;
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          // A request granted on the flush cycle is still owed a response; drop it.
          if (req && bus.ib_gnt) begin
            state_q <= StWait;
            drop_q  <= 1'b1;
          end else begin
            state_q <= StReq;
          end
        end
        StWait: begin
          if (bus.ib_rvalid) begin
            state_q <= StReq;
            drop_q  <= 1'b0;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        StHold: state_q <= StReq;
        default: state_q <= StIdle;
      endcase
    end else begin
      if (bus.br_flag && !bus.id_stall) begin
        br_pend_q <= 1'b1;
        br_tgt_q  <= bus.br_addr;
      end
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (adel) begin
            buf_pc_q   <= fetch_pc_q;
            buf_inst_q <= 32'h0;
            buf_adel_q <= 1'b1;
            state_q    <= StHold;
          end else if (bus.ib_gnt) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.ib_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              buf_pc_q   <= fetch_pc_q;
              buf_inst_q <= bus.ib_rdata;
              buf_adel_q <= 1'b0;
              state_q    <= StHold;
            end
          end
        end
        StHold: begin
          if (!bus.id_stall) begin
            // A branch accepted alongside this slot makes it the delay slot: go to target next.
            if (bus.br_flag) begin
              fetch_pc_q <= bus.br_addr;
            end else if (br_pend_q) begin
              fetch_pc_q <= br_tgt_q;
            end else begin
              fetch_pc_q <= buf_pc_q + 32'd4;
            end
            br_pend_q <= 1'b0;
            state_q   <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus a hand-written
// asynchronous-reset-in-WAIT sequence.
module tb_fetch_ctrl;

  logic clk;
  logic rst_ni;
  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        bf;
    logic [31:0] ba;
    logic        um;
    logic        st;
    logic        gn;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_adel;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic bf,
                              input logic [31:0] ba, input logic um, input logic st,
                              input logic gn, input logic rv, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic e_adel);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.bf = bf; v.ba = ba; v.um = um; v.st = st;
    v.gn = gn; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_adel = e_adel;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_outs(input int row, input logic e_req, input logic [31:0] e_addr,
                            input logic e_val, input logic [31:0] e_pc,
                            input logic [31:0] e_inst, input logic e_adel);
    check("ib_req",   row, {31'h0, bus.ib_req},   {31'h0, e_req});
    check("ib_addr",  row, bus.ib_addr,           e_addr);
    check("if_valid", row, {31'h0, bus.if_valid}, {31'h0, e_val});
    check("if_pc",    row, bus.if_pc,             e_pc);
    check("if_inst",  row, bus.if_inst,           e_inst);
    check("if_adel",  row, {31'h0, bus.if_adel},  {31'h0, e_adel});
  endtask

  task automatic drive(input vec_t v);
    bus.flush     = v.fl;
    bus.flush_pc  = v.fpc;
    bus.br_flag   = v.bf;
    bus.br_addr   = v.ba;
    bus.usermode  = v.um;
    bus.id_stall  = v.st;
    bus.ib_gnt    = v.gn;
    bus.ib_rvalid = v.rv;
    bus.ib_rdata  = v.rd;
  endtask

  localparam logic [31:0] RPC = 32'hBFC0_0000;
  localparam logic [31:0] Z   = 32'h0;

  initial begin
    clk     = 1'b0;
    rst_ni  = 1'b1;
    n_tests = 0;
    n_fail  = 0;
    drive(mk(0, Z, 0, Z, 0, 0, 0, 0, Z, 0, Z, 0, Z, Z, 0));

    //       fl fpc           bf ba            um st gn rv rdata        | req addr        val pc            inst          adel
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, RPC,          0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, RPC,          0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h11111111, 0, RPC,          0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 1, 0, 0, Z,            0, RPC,          1, RPC,          32'h11111111, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 1, 0, 0, Z,            0, RPC,          1, RPC,          32'h11111111, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 1, 0, 0, Z,            0, RPC,          1, RPC,          32'h11111111, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, RPC,          1, RPC,          32'h11111111, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            1, 32'hBFC00004, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, 32'hBFC00004, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'hBFC00004, 0, Z,            Z,            0));
    // Branch while the delay slot is in WAIT.
    vecs.push_back(mk(0, Z,            1, 32'h80001000, 0, 0, 0, 0, Z,            0, 32'hBFC00004, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h22222222, 0, 32'hBFC00004, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'hBFC00004, 1, 32'hBFC00004, 32'h22222222, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, 32'h80001000, 0, Z,            Z,            0));
    // Flush in WAIT together with a branch; response two cycles later is dropped.
    vecs.push_back(mk(1, 32'h80000180, 1, 32'h12345678, 0, 0, 0, 0, Z,            0, 32'h80001000, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'h80000180, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h33333333, 0, 32'h80000180, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, 32'h80000180, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h44444444, 0, 32'h80000180, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'h80000180, 1, 32'h80000180, 32'h44444444, 0));
    // Flush in REQ (no grant), then user-mode kernel address -> AdEL.
    vecs.push_back(mk(1, 32'h80000000, 0, Z,            0, 0, 0, 0, Z,            1, 32'h80000184, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            1, 0, 0, 0, Z,            0, 32'h80000000, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            1, 1, 0, 0, Z,            0, 32'h80000000, 1, 32'h80000000, Z,            1));
    vecs.push_back(mk(1, 32'h00400002, 0, Z,            0, 0, 0, 0, Z,            0, 32'h80000000, 1, 32'h80000000, Z,            1));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'h00400002, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 1, 0, 0, Z,            0, 32'h00400002, 1, 32'h00400002, Z,            1));
    vecs.push_back(mk(1, 32'h00400000, 0, Z,            0, 1, 0, 0, Z,            0, 32'h00400002, 1, 32'h00400002, Z,            1));
    // Stray rvalid in REQ is ignored.
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 1, 32'hDEADBEEF, 1, 32'h00400000, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h55555555, 0, 32'h00400000, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 1, 0, 0, Z,            0, 32'h00400000, 1, 32'h00400000, 32'h55555555, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'h00400000, 1, 32'h00400000, 32'h55555555, 0));
    // Flush in REQ with grant on the same cycle -> response dropped.
    vecs.push_back(mk(1, 32'h80000200, 0, Z,            0, 0, 1, 0, Z,            1, 32'h00400004, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h66666666, 0, 32'h80000200, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            1, 32'h80000200, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, 32'h80000200, 0, Z,            Z,            0));
    // Flush in WAIT on the rvalid cycle.
    vecs.push_back(mk(1, 32'h80000300, 0, Z,            0, 0, 0, 1, 32'h77777777, 0, 32'h80000200, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            1, 32'h80000300, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, 32'h80000300, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h88888888, 0, 32'h80000300, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 1, 0, 0, Z,            0, 32'h80000300, 1, 32'h80000300, 32'h88888888, 0));
    // PC+4 wraps at the top of the address space.
    vecs.push_back(mk(1, 32'hFFFFFFFC, 0, Z,            0, 1, 0, 0, Z,            0, 32'h80000300, 1, 32'h80000300, 32'h88888888, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 1, 0, Z,            1, 32'hFFFFFFFC, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 1, 32'h12121212, 0, 32'hFFFFFFFC, 0, Z,            Z,            0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h12121212, 0));
    vecs.push_back(mk(0, Z,            0, Z,            0, 0, 0, 0, Z,            1, 32'h00000000, 0, Z,            Z,            0));

    #2 rst_ni = 1'b0;
    @(negedge clk);
    #1 check_outs(-1, 0, RPC, 0, Z, Z, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1 check_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val,
                    vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_adel);
    end

    // Asynchronous reset while in WAIT; a late response must be ignored.
    @(negedge clk);
    drive(mk(0, Z, 0, Z, 0, 0, 1, 0, Z, 0, Z, 0, Z, Z, 0));
    @(negedge clk);
    bus.ib_gnt = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check_outs(100, 0, RPC, 0, Z, Z, 0);
    @(negedge clk);
    bus.ib_rvalid = 1'b1;
    bus.ib_rdata  = 32'h99999999;
    @(negedge clk);
    rst_ni = 1'b1;
    #1 check_outs(101, 0, RPC, 0, Z, Z, 0);
    @(negedge clk);
    #1 check_outs(102, 1, RPC, 0, Z, Z, 0);
    bus.ib_gnt    = 1'b1;
    bus.ib_rvalid = 1'b0;
    @(negedge clk);
    bus.ib_gnt    = 1'b0;
    bus.ib_rvalid = 1'b1;
    bus.ib_rdata  = 32'hAAAA5555;
    #1 check_outs(103, 0, RPC, 0, Z, Z, 0);
    @(negedge clk);
    bus.ib_rvalid = 1'b0;
    bus.id_stall  = 1'b1;
    #1 check_outs(104, 0, RPC, 1, RPC, 32'hAAAA5555, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
